// File: rtl/writeback_pkg.sv
// Opcode classes, source-select codes and FSM state shared by the writeback stage.
package writeback_pkg;

  localparam logic [5:0] OPC_MOV    = 6'h04;
  localparam logic [5:0] OPC_LDI    = 6'h05;
  localparam logic [5:0] OPC_ALU_LO = 6'h08;
  localparam logic [5:0] OPC_ALU_HI = 6'h0F;
  localparam logic [5:0] OPC_LD     = 6'h10;
  localparam logic [5:0] OPC_ST     = 6'h11;

  typedef enum logic [2:0] {
    SEL_RS1,
    SEL_IMM,
    SEL_ALU,
    SEL_DM,
    SEL_NONE,
    SEL_ILL
  } sel_t;

  typedef enum logic {
    IDLE,
    LOAD_WAIT
  } state_t;

endpackage

// File: rtl/wb_opc_decode.sv
// Combinational opcode -> result-source decode; zero latency, no flow control.
module wb_opc_decode
  import writeback_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  logic [OPC_W-1:0] opc,
  output sel_t             sel
);

  always_comb begin
    sel = SEL_ILL;
    if (opc == OPC_W'(OPC_MOV))
      sel = SEL_RS1;
    else if (opc == OPC_W'(OPC_LDI))
      sel = SEL_IMM;
    else if (opc >= OPC_W'(OPC_ALU_LO) && opc <= OPC_W'(OPC_ALU_HI))
      sel = SEL_ALU;
    else if (opc == OPC_W'(OPC_LD))
      sel = SEL_DM;
    else if (opc == OPC_W'(OPC_ST))
      sel = SEL_NONE;
  end

endmodule

// File: rtl/writeback_select.sv
// Writeback stage: 1-cycle result for MOV/LDI/ALU, loads wait for DM_VALID with IN_READY low.
// Define WB_TIMEOUT_EN to add the LOAD_WAIT watchdog (WB_ERR after LOAD_TIMEOUT idle wait cycles).
module writeback_select
  import writeback_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int OPC_W        = 6,
  parameter int RD_W         = 5,
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [OPC_W-1:0]  OPC,
  input  logic [RD_W-1:0]   RD_ADDR,
  input  logic [DATA_W-1:0] RS1,
  input  logic [DATA_W-1:0] IMMVAL,
  input  logic [DATA_W-1:0] ALUOUT,
  input  logic [DATA_W-1:0] DOUT_DM,
  input  logic              DM_VALID,
  output logic              WB_VALID,
  output logic [RD_W-1:0]   WB_ADDR,
  output logic [DATA_W-1:0] WB_DATA,
  output logic              WB_ERR
);

  state_t            state, state_nxt;
  sel_t              sel;
  logic [DATA_W-1:0] src_data;
  logic              wb_valid_q, wb_valid_nxt;
  logic              wb_err_q, wb_err_nxt;
  logic [DATA_W-1:0] wb_data_q, wb_data_nxt;
  logic [RD_W-1:0]   wb_addr_q, wb_addr_nxt;
  logic [RD_W-1:0]   rd_cap_q, rd_cap_nxt;

`ifdef WB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(LOAD_TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_nxt;
`else
  logic unused_cfg;
  assign unused_cfg = (LOAD_TIMEOUT == 0);
`endif

  wb_opc_decode #(.OPC_W(OPC_W)) u_decode (
    .opc (OPC),
    .sel (sel)
  );

  always_comb begin
    src_data = ALUOUT;
    case (sel)
      SEL_RS1: src_data = RS1;
      SEL_IMM: src_data = IMMVAL;
      default: src_data = ALUOUT;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    wb_valid_nxt = 1'b0;
    wb_err_nxt   = 1'b0;
    wb_data_nxt  = wb_data_q;
    wb_addr_nxt  = wb_addr_q;
    rd_cap_nxt   = rd_cap_q;
`ifdef WB_TIMEOUT_EN
    cnt_nxt      = cnt_q;
`endif
    case (state)
      IDLE: begin
        if (IN_VALID) begin
          case (sel)
            SEL_RS1, SEL_IMM, SEL_ALU: begin
              // Register 0 is hardwired: no strobe, and outputs keep their last write.
              if (RD_ADDR != '0) begin
                wb_valid_nxt = 1'b1;
                wb_addr_nxt  = RD_ADDR;
                wb_data_nxt  = src_data;
              end
            end
            SEL_DM: begin
              rd_cap_nxt = RD_ADDR;
              state_nxt  = LOAD_WAIT;
`ifdef WB_TIMEOUT_EN
              cnt_nxt    = '0;
`endif
            end
            SEL_ILL: wb_err_nxt = 1'b1;
            default: ;
          endcase
        end
      end
      LOAD_WAIT: begin
        // Returning data takes priority over the watchdog on the same edge.
        if (DM_VALID) begin
          state_nxt = IDLE;
          if (rd_cap_q != '0) begin
            wb_valid_nxt = 1'b1;
            wb_addr_nxt  = rd_cap_q;
            wb_data_nxt  = DOUT_DM;
          end
        end
`ifdef WB_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          state_nxt  = IDLE;
          wb_err_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_q + 8'd1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      wb_valid_q <= 1'b0;
      wb_err_q   <= 1'b0;
      wb_data_q  <= '0;
      wb_addr_q  <= '0;
      rd_cap_q   <= '0;
`ifdef WB_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state      <= state_nxt;
      wb_valid_q <= wb_valid_nxt;
      wb_err_q   <= wb_err_nxt;
      wb_data_q  <= wb_data_nxt;
      wb_addr_q  <= wb_addr_nxt;
      rd_cap_q   <= rd_cap_nxt;
`ifdef WB_TIMEOUT_EN
      cnt_q      <= cnt_nxt;
`endif
    end
  end

  assign IN_READY = (state == IDLE);
  assign WB_VALID = wb_valid_q;
  assign WB_ERR   = wb_err_q;
  assign WB_DATA  = wb_data_q;
  assign WB_ADDR  = wb_addr_q;

endmodule

// File: tb/tb_writeback_select.sv
// Bench for writeback_select: vector table plus hand sequences, outputs matched against a queue.
module tb_writeback_select;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        IN_VALID;
  logic        IN_READY;
  logic [5:0]  OPC;
  logic [4:0]  RD_ADDR;
  logic [31:0] RS1, IMMVAL, ALUOUT, DOUT_DM;
  logic        DM_VALID;
  logic        WB_VALID;
  logic [4:0]  WB_ADDR;
  logic [31:0] WB_DATA;
  logic        WB_ERR;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  writeback_select #(.DATA_W(32), .OPC_W(6), .RD_W(5), .LOAD_TIMEOUT(4)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .OPC      (OPC),
    .RD_ADDR  (RD_ADDR),
    .RS1      (RS1),
    .IMMVAL   (IMMVAL),
    .ALUOUT   (ALUOUT),
    .DOUT_DM  (DOUT_DM),
    .DM_VALID (DM_VALID),
    .WB_VALID (WB_VALID),
    .WB_ADDR  (WB_ADDR),
    .WB_DATA  (WB_DATA),
    .WB_ERR   (WB_ERR)
  );

  typedef struct packed {
    logic        v;
    logic        e;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  typedef struct {
    logic [5:0]  opc;
    logic [4:0]  rd;
    logic [31:0] rs1, imm, alu;
    logic        v, e;
    logic [31:0] d;
  } vec_t;

  exp_t        sb[$];
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
    sb.push_back('{v: 1'b1, e: 1'b0, a: a, d: d});
    last_addr = a;
    last_data = d;
  endtask

  task automatic push_err();
    sb.push_back('{v: 1'b0, e: 1'b1, a: last_addr, d: last_data});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Every output event must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (WB_VALID === 1'b1 || WB_ERR === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {25'd0, WB_VALID, WB_ERR, WB_ADDR, WB_DATA}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_event", {25'd0, WB_VALID, WB_ERR, WB_ADDR, WB_DATA}, {25'd0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{6'h05, 5'd7,  32'd1, 32'd2,  32'd5,          1'b1, 1'b0, 32'd2};
    vecs[1]  = '{6'h04, 5'd3,  32'd1, 32'd2,  32'd5,          1'b1, 1'b0, 32'd1};
    vecs[2]  = '{6'h0C, 5'd4,  32'd1, 32'd2,  32'd5,          1'b1, 1'b0, 32'd5};
    vecs[3]  = '{6'h08, 5'd31, 32'd9, 32'd9,  32'hDEADBEEF,   1'b1, 1'b0, 32'hDEADBEEF};
    vecs[4]  = '{6'h0F, 5'd1,  32'd9, 32'd9,  32'h00001234,   1'b1, 1'b0, 32'h00001234};
    vecs[5]  = '{6'h3F, 5'd9,  32'd7, 32'd7,  32'd7,          1'b0, 1'b1, 32'd0};
    vecs[6]  = '{6'h11, 5'd9,  32'd7, 32'd7,  32'd7,          1'b0, 1'b0, 32'd0};
    vecs[7]  = '{6'h04, 5'd0,  32'hAA, 32'd7, 32'd7,          1'b0, 1'b0, 32'd0};
    vecs[8]  = '{6'h07, 5'd2,  32'd7, 32'd7,  32'd7,          1'b0, 1'b1, 32'd0};
    vecs[9]  = '{6'h05, 5'd10, 32'd7, 32'hCAFE0001, 32'd7,    1'b1, 1'b0, 32'hCAFE0001};
    vecs[10] = '{6'h12, 5'd2,  32'd7, 32'd7,  32'd7,          1'b0, 1'b1, 32'd0};
    vecs[11] = '{6'h00, 5'd2,  32'd7, 32'd7,  32'd7,          1'b0, 1'b1, 32'd0};

    reset_n = 1'b0; IN_VALID = 1'b0; OPC = '0; RD_ADDR = '0;
    RS1 = 32'd1; IMMVAL = 32'd2; ALUOUT = 32'd5; DOUT_DM = 32'd3; DM_VALID = 1'b0;
    step(); step();
    chk("reset_outputs", {30'd0, WB_VALID, WB_ERR, WB_ADDR, WB_DATA}, 64'd0);
    chk("reset_in_ready", {63'd0, IN_READY}, 64'd1);
    reset_n = 1'b1;
    step();

    // Back-to-back table: one instruction accepted per cycle.
    foreach (vecs[i]) begin
      OPC = vecs[i].opc; RD_ADDR = vecs[i].rd;
      RS1 = vecs[i].rs1; IMMVAL = vecs[i].imm; ALUOUT = vecs[i].alu;
      IN_VALID = 1'b1;
      chk($sformatf("in_ready_vec%0d", i), {63'd0, IN_READY}, 64'd1);
      if (vecs[i].v) push_wr(vecs[i].rd, vecs[i].d);
      if (vecs[i].e) push_err();
      step();
    end
    IN_VALID = 1'b0;
    step(); step();
    chk("table_drained", 64'(sb.size()), 64'd0);

    // Load, data 3 cycles later; DM_VALID in the acceptance cycle is ignored.
    OPC = 6'h10; RD_ADDR = 5'd9; DOUT_DM = 32'h77; DM_VALID = 1'b1; IN_VALID = 1'b1;
    step();
    DM_VALID = 1'b0; OPC = 6'h04; RD_ADDR = 5'd5; RS1 = 32'h55;
    chk("load_wait_ready", {63'd0, IN_READY}, 64'd0);
    step(); step();
    chk("load_wait_ready2", {63'd0, IN_READY}, 64'd0);
    DOUT_DM = 32'd3; DM_VALID = 1'b1;
    push_wr(5'd9, 32'd3);
    step();
    DM_VALID = 1'b0;
    chk("load_done_ready", {63'd0, IN_READY}, 64'd1);
    push_wr(5'd5, 32'h55);
    step();
    IN_VALID = 1'b0;
    step();
    chk("load_drained", 64'(sb.size()), 64'd0);

    // Minimum-latency load to r0: waits for data but never writes.
    OPC = 6'h10; RD_ADDR = 5'd0; IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0; DM_VALID = 1'b1; DOUT_DM = 32'hBAD;
    chk("r0_load_wait", {63'd0, IN_READY}, 64'd0);
    step();
    DM_VALID = 1'b0;
    chk("r0_load_ready", {63'd0, IN_READY}, 64'd1);
    step();
    chk("r0_hold", {27'd0, WB_ADDR, WB_DATA}, {27'd0, last_addr, last_data});

    // Reset in the middle of a load abandons it.
    OPC = 6'h10; RD_ADDR = 5'd6; IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    chk("midreset_outputs", {30'd0, WB_VALID, WB_ERR, WB_ADDR, WB_DATA}, 64'd0);
    chk("midreset_ready", {63'd0, IN_READY}, 64'd1);
    last_addr = '0; last_data = '0;
    reset_n = 1'b1; DM_VALID = 1'b1; DOUT_DM = 32'h99;
    step(); step();
    DM_VALID = 1'b0;
    chk("midreset_nowrite", {30'd0, WB_VALID, WB_ERR, WB_ADDR, WB_DATA}, 64'd0);

    // Data arriving on the 4th wait edge beats the watchdog.
    OPC = 6'h10; RD_ADDR = 5'd12; IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    step(); step(); step();
    DM_VALID = 1'b1; DOUT_DM = 32'h4444;
    push_wr(5'd12, 32'h4444);
    step();
    DM_VALID = 1'b0;
    chk("boundary_ready", {63'd0, IN_READY}, 64'd1);

    // No data at all.
    OPC = 6'h10; RD_ADDR = 5'd13; IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    step(); step(); step();
    chk("timeout_pre_ready", {63'd0, IN_READY}, 64'd0);
`ifdef WB_TIMEOUT_EN
    push_err();
    step();
    chk("timeout_ready", {63'd0, IN_READY}, 64'd1);
    step();
`else
    repeat (20) step();
    chk("nowatchdog_still_waiting", {63'd0, IN_READY}, 64'd0);
    DM_VALID = 1'b1; DOUT_DM = 32'h5151;
    push_wr(5'd13, 32'h5151);
    step();
    DM_VALID = 1'b0;
    chk("nowatchdog_ready", {63'd0, IN_READY}, 64'd1);
    step();
`endif
    step();
    chk("final_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_select.md
# writeback_select

Parametrised writeback stage for the 32-bit CPU, replacing the fixed four-input result mux. It accepts one retiring instruction per handshake and selects its result from RS1, IMMVAL, DOUT_DM or ALUOUT by opcode class. Results are registered with a destination address, and loads stall until data memory returns DOUT_DM. It sits between execute/memory and the register file write port.

## Interface
- DATA_W, 32, result/operand width
- OPC_W, 6, opcode width
- RD_W, 5, destination register address width
- LOAD_TIMEOUT, 15, cycles allowed in LOAD_WAIT before error (1..2^8-1; counter 8 bits)
- clock  in  1  single clock; all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- IN_VALID  in  1  retiring instruction present
- IN_READY  out  1  stage can accept (high only in IDLE)
- OPC  in  OPC_W  opcode of retiring instruction
- RD_ADDR  in  RD_W  destination register
- RS1, IMMVAL, ALUOUT  in  DATA_W  candidate results, sampled at acceptance
- DOUT_DM  in  DATA_W  data memory read data
- DM_VALID  in  1  DOUT_DM valid this cycle
- WB_VALID  out  1  one-cycle register-file write strobe
- WB_ADDR  out  RD_W  write address
- WB_DATA  out  DATA_W  write data
- WB_ERR  out  1  one-cycle error pulse (illegal opcode or load timeout)

## Operation
- Acceptance: IN_VALID && IN_READY on a rising edge.
- Opcode classes (package constants): OPC_MOV=6'h04 -> RS1; OPC_LDI=6'h05 -> IMMVAL; OPC_ALU range 6'h08..6'h0F -> ALUOUT; OPC_LD=6'h10 -> DOUT_DM; OPC_ST=6'h11 -> no writeback, no error; all others illegal.
- FSM states: IDLE, LOAD_WAIT.
- IDLE, non-load accepted: WB_DATA/WB_ADDR loaded with the selected source and RD_ADDR; WB_VALID=1 for one cycle; state stays IDLE.
- IDLE, OPC_LD accepted: RD_ADDR captured, timeout counter cleared, -> LOAD_WAIT; IN_READY=0.
- LOAD_WAIT, DM_VALID=1: WB_DATA<=DOUT_DM, WB_ADDR<=captured address, WB_VALID pulse, -> IDLE.
- LOAD_WAIT, DM_VALID=0: counter increments.
- Illegal opcode: WB_ERR pulse, WB_VALID=0, WB_DATA/WB_ADDR hold.
- RD_ADDR==0: register 0 is hardwired. WB_VALID is suppressed for MOV/LDI/ALU/LD, but the load still waits for DM_VALID.
- WB_DATA/WB_ADDR hold their last value when WB_VALID=0.

## Timing
- Reset (reset_n=0 at edge): state IDLE; WB_VALID=0, WB_ERR=0, WB_DATA=0, WB_ADDR=0, counter=0; IN_READY=1 the following cycle.
- Non-load latency: 1 cycle from acceptance edge to WB_VALID.
- Load latency: WB_VALID asserts the cycle after the first edge in LOAD_WAIT that samples DM_VALID=1. Minimum is 2 cycles from acceptance.
- DM_VALID while in IDLE is ignored, including in the acceptance cycle of the load itself.
- DM_VALID on the same edge the counter reaches LOAD_TIMEOUT: data wins, normal writeback, no WB_ERR.
- Reset during LOAD_WAIT: the load is abandoned with no WB_VALID and no WB_ERR.
- Back-to-back non-loads are accepted every cycle, each giving one WB_VALID.

## Configuration
- WB_TIMEOUT_EN defined: the LOAD_WAIT watchdog is present. After LOAD_TIMEOUT cycles without DM_VALID, it pulses WB_ERR, makes no write, and returns to IDLE.
- WB_TIMEOUT_EN undefined: no counter logic. LOAD_WAIT waits indefinitely, and WB_ERR reports only illegal opcodes.

## Structure
- Package writeback_pkg: opcode constants (OPC_MOV, OPC_LDI, OPC_ALU_LO/HI, OPC_LD, OPC_ST), source-select enum (SEL_RS1, SEL_IMM, SEL_ALU, SEL_DM, SEL_NONE, SEL_ILL), FSM state typedef.
- One sub-module, wb_opc_decode: combinational OPC -> source-select decode. FSM, counter and output registers live in writeback_select.

## Test plan
- Reset, then RS1=1, IMMVAL=2, DOUT_DM=3, ALUOUT=5, RD_ADDR=7, OPC=6'h05 for one accepted cycle -> next cycle WB_VALID=1, WB_ADDR=7, WB_DATA=2.
- Back-to-back OPC=6'h04 then 6'h0C -> WB_DATA=1 then 5 on consecutive cycles, IN_READY held 1.
- OPC=6'h10, DM_VALID raised 3 cycles later with DOUT_DM=3 -> IN_READY=0 during wait, single WB_VALID with WB_DATA=3, then IN_READY=1.
- OPC=6'h3F -> WB_ERR pulse, WB_VALID=0. OPC=6'h11 -> neither WB_ERR nor WB_VALID.
- With WB_TIMEOUT_EN and LOAD_TIMEOUT=4, OPC=6'h10 and DM_VALID never raised -> WB_ERR pulse after 4 wait cycles, no write, back to IDLE.
- Load with RD_ADDR=0 -> no WB_VALID. Load, then reset_n=0 mid-wait -> outputs zero, IDLE, a later DM_VALID causes no write.
